// File: rtl/cim_bitserial_add_ctrl.sv
// cim_bitserial_add_ctrl: sequences parallel loads, a bit-serial ripple add and readback over three CIM word arrays.
module cim_bitserial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] arr_din,
  output logic [2:0]       gwl,
  output logic             arr_write,
  output logic             arr_read,
  output logic             clr_s,
  output logic [WIDTH-1:0] rwl_a,
  output logic [WIDTH-1:0] rwl_b,
  output logic [WIDTH-1:0] wwl_s,
  input  logic             bit_a,
  input  logic             bit_b,
  output logic             sum_bit,
  input  logic [WIDTH-1:0] s_dout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, CLR, ADD, RD1, RD2, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] din_q, wl;
  logic carry, sel_b, last, maj, rd;
  assign last = cnt == CW'(WIDTH - 1);
  assign maj = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
  assign rd = state == RD1 || state == RD2;
  assign wl = state == ADD ? WIDTH'(1) << cnt : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign arr_din = state == LOAD ? din_q : '0;
  assign gwl = state == LOAD ? {1'b0, sel_b, ~sel_b} : rd ? 3'b100 : 3'b000;
  assign arr_write = state == LOAD;
  assign arr_read = rd;
  assign clr_s = state == CLR;
  assign rwl_a = wl;
  assign rwl_b = wl;
  assign wwl_s = wl;
  assign sum_bit = bit_a ^ bit_b ^ carry;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !start ? IDLE : op == 2'b10 ? CLR : op == 2'b11 ? RD1 : LOAD;
      LOAD: nxt = DONE;
      CLR:  nxt = ADD;
      ADD:  nxt = last ? DONE : ADD;
      RD1:  nxt = RD2;
      RD2:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      din_q <= '0;
      sel_b <= 1'b0;
      data_out <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start && !op[1]) begin
        din_q <= data_in;
        sel_b <= op[0];
      end
      if (state == CLR) begin
        carry <= 1'b0;
        cnt <= '0;
      end
      if (state == ADD) begin
        carry <= maj;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) carry_out <= maj;
      end
      if (state == RD2) data_out <= s_dout;
    end
  end
endmodule

// File: tb/tb_cim_bitserial_add_ctrl.sv
// tb_cim_bitserial_add_ctrl: random command streams against an arithmetic reference, with a queue-based done monitor.
module tb_cim_bitserial_add_ctrl;
  localparam int W = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] op = '0;
  logic [W-1:0] data_in = '0;
  logic busy, done, carry_out, arr_write, arr_read, clr_s, bit_a, bit_b, sum_bit;
  logic [W-1:0] data_out, arr_din, rwl_a, rwl_b, wwl_s, s_dout;
  logic [2:0] gwl;
  logic [W-1:0] mem_a = '0, mem_b = '0, mem_s = '0;
  int cyc = 0, checks = 0, errors = 0;
  logic [W-1:0] ref_a = '0, ref_b = '0, ref_s = '0;
  logic ref_c = 0, s_ok = 0;
  typedef struct {logic [1:0] op; logic [W-1:0] d; logic c; logic chk_d; int t;} exp_t;
  exp_t q[$];

  cim_bitserial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .carry_out(carry_out),
    .arr_din(arr_din), .gwl(gwl), .arr_write(arr_write), .arr_read(arr_read),
    .clr_s(clr_s), .rwl_a(rwl_a), .rwl_b(rwl_b), .wwl_s(wwl_s),
    .bit_a(bit_a), .bit_b(bit_b), .sum_bit(sum_bit), .s_dout(s_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural storage arrays: parallel write/clear/read plus per-word-line serial access.
  assign bit_a = |(mem_a & rwl_a);
  assign bit_b = |(mem_b & rwl_b);
  assign s_dout = (arr_read && gwl[2]) ? mem_s : '0;
  always @(posedge clk) begin
    if (arr_write && gwl[0]) mem_a <= arr_din;
    if (arr_write && gwl[1]) mem_b <= arr_din;
    if (clr_s) mem_s <= '0;
    else for (int i = 0; i < W; i++) if (wwl_s[i]) mem_s[i] <= sum_bit;
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(rwl_a) || !$onehot0(rwl_b) || !$onehot0(wwl_s) ||
          (arr_write && (arr_read || clr_s || |wwl_s))) begin
        errors++;
        $display("FAIL protocol cyc=%0d rwl_a=%h rwl_b=%h wwl_s=%h wr=%b rd=%b clr=%b",
                 cyc, rwl_a, rwl_b, wwl_s, arr_write, arr_read, clr_s);
      end
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got done=1 required no pending command", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc != e.t) begin
            errors++;
            $display("FAIL latency op=%0d got cyc=%0d required cyc=%0d", e.op, cyc, e.t);
          end
          checks++;
          if (carry_out !== e.c) begin
            errors++;
            $display("FAIL carry_out op=%0d got %b required %b", e.op, carry_out, e.c);
          end
          if (e.op == 2'b11 && e.chk_d) begin
            checks++;
            if (data_out !== e.d) begin
              errors++;
              $display("FAIL data_out got %h required %h", data_out, e.d);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] o, input logic [W-1:0] d, input int t0);
    exp_t e;
    case (o)
      2'b00: ref_a = d;
      2'b01: ref_b = d;
      2'b10: begin
        {ref_c, ref_s} = {1'b0, ref_a} + {1'b0, ref_b};
        s_ok = 1;
      end
      default: ;
    endcase
    e.op = o;
    e.d = ref_s;
    e.c = ref_c;
    e.chk_d = s_ok;
    e.t = t0 + (o == 2'b10 ? W + 2 : o == 2'b11 ? 3 : 2);
    q.push_back(e);
  endtask

  task automatic check_reset_outs(input string name);
    checks++;
    if ({busy, done, data_out, carry_out, arr_din, gwl, arr_write, arr_read, clr_s,
         rwl_a, rwl_b, wwl_s, sum_bit} !== '0) begin
      errors++;
      $display("FAIL %s busy=%b done=%b dout=%h cout=%b din=%h gwl=%b wr=%b rd=%b clr=%b rwl=%h wwl=%h sum=%b required all 0",
               name, busy, done, data_out, carry_out, arr_din, gwl, arr_write, arr_read,
               clr_s, rwl_a, wwl_s, sum_bit);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
  task automatic run_cmd(input logic [1:0] o, input logic [W-1:0] d, input int mode);
    int k;
    logic [W-1:0] exp_wl;
    start = 1;
    op = o;
    data_in = d;
    push_exp(o, d, cyc);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (mode == 2) begin
        start = (k == 4);
        op = 2'b01;
        data_in = 8'h77;
      end else start = 0;
      if (mode == 1 && k >= 2 && k <= W + 1) begin
        exp_wl = 8'h01 << (k - 2);
        checks++;
        if (rwl_a !== exp_wl || rwl_b !== exp_wl || wwl_s !== exp_wl) begin
          errors++;
          $display("FAIL wordline k=%0d got rwl_a=%h rwl_b=%h wwl_s=%h required %h",
                   k, rwl_a, rwl_b, wwl_s, exp_wl);
        end
      end
      if (mode == 2 && k <= W + 2) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_hold k=%0d got %b required 1", k, busy);
        end
      end
      if (mode == 3 && k == 7) begin
        rst = 1;
        #1;
        check_reset_outs("async_reset");
        q.delete(q.size() - 1);
        ref_c = 0;
        s_ok = 0;
        @(negedge clk);
        rst = 0;
        return;
      end
      if (!busy) break;
      if (k > 40) begin
        errors++;
        $display("FAIL timeout op=%0d got busy after %0d cycles required idle", o, k);
        break;
      end
    end
  endtask

  task automatic add_and_read(input logic [W-1:0] a, input logic [W-1:0] b);
    run_cmd(2'b00, a, 0);
    run_cmd(2'b01, b, 0);
    run_cmd(2'b10, 0, 0);
    run_cmd(2'b11, 0, 0);
  endtask

  logic [W-1:0] corner_a[6] = '{8'h5A, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h01};
  logic [W-1:0] corner_b[6] = '{8'h33, 8'h01, 8'h00, 8'hFF, 8'h80, 8'hFF};

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    rst = 0;
    @(negedge clk);
    run_cmd(2'b00, 8'h5A, 0);
    run_cmd(2'b01, 8'h33, 0);
    run_cmd(2'b10, 0, 1);
    run_cmd(2'b11, 0, 0);
    add_and_read(8'hFF, 8'h01);
    add_and_read(8'h00, 8'h00);
    run_cmd(2'b00, 8'h10, 0);
    run_cmd(2'b01, 8'h20, 0);
    run_cmd(2'b10, 0, 2);
    run_cmd(2'b11, 0, 0);
    run_cmd(2'b10, 0, 3);
    run_cmd(2'b00, 8'h0F, 0);
    run_cmd(2'b01, 8'hF0, 0);
    run_cmd(2'b10, 0, 0);
    run_cmd(2'b11, 0, 0);
    // start held high: every IDLE edge accepts whatever op is presented
    start = 1;
    for (int n = 0; n < 60; n++) begin
      int w;
      w = 0;
      while (busy && w < 40) begin
        op = 2'($urandom);
        data_in = W'($urandom);
        @(negedge clk);
        w++;
      end
      if (w >= 40) begin
        errors++;
        $display("FAIL held_timeout got busy=1 required idle");
        break;
      end
      op = 2'($urandom);
      data_in = W'($urandom);
      push_exp(op, data_in, cyc);
      @(negedge clk);
    end
    while (busy) @(negedge clk);
    start = 0;
    for (int i = 0; i < 6; i++) add_and_read(corner_a[i], corner_b[i]);
    for (int i = 0; i < 150; i++) add_and_read(W'($urandom), W'($urandom));
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_done got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
